// File: rtl/sync_fifo_pf.sv
// Synchronous FIFO with level, programmable almost-full/almost-empty flags,
// sticky overflow/underflow, flush, and selectable registered or FWFT read port.
module sync_fifo_pf #(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned ADDRESS_WIDTH = 4,
   parameter int unsigned FWFT          = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     write_increment,
   input  logic [DATA_WIDTH-1:0]    write_data,
   input  logic                     read_increment,
   output logic [DATA_WIDTH-1:0]    read_data,
   output logic                     read_valid,
   output logic                     full,
   output logic                     empty,
   output logic [ADDRESS_WIDTH:0]   level,
   input  logic [ADDRESS_WIDTH:0]   af_thresh,
   input  logic [ADDRESS_WIDTH:0]   ae_thresh,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic                     overflow,
   output logic                     underflow,
   input  logic                     error_clear
);

   localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;
   localparam logic [ADDRESS_WIDTH:0] LEVEL_FULL = {1'b1, {ADDRESS_WIDTH{1'b0}}};

   logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
   logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDRESS_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDRESS_WIDTH:0]   level_q, level_d;
   logic [DATA_WIDTH-1:0]    read_data_q, read_data_d;
   logic                     read_valid_q, read_valid_d;
   logic                     overflow_q, overflow_d;
   logic                     underflow_q, underflow_d;
   logic                     full_int, empty_int;
   logic                     wr_accept, rd_accept;

   always_comb begin
      full_int     = (level_q == LEVEL_FULL);
      empty_int    = (level_q == '0);
      wr_accept    = write_increment && !full_int && !flush;
      rd_accept    = read_increment && !empty_int && !flush;

      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      level_d      = level_q;
      read_data_d  = read_data_q;
      read_valid_d = rd_accept;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (wr_accept) wr_ptr_d = wr_ptr_q + ADDRESS_WIDTH'(1);
         if (rd_accept) rd_ptr_d = rd_ptr_q + ADDRESS_WIDTH'(1);
         if (wr_accept && !rd_accept)
            level_d = level_q + (ADDRESS_WIDTH+1)'(1);
         else if (rd_accept && !wr_accept)
            level_d = level_q - (ADDRESS_WIDTH+1)'(1);
      end

      if (rd_accept) read_data_d = mem_q[rd_ptr_q];

      // A fresh error event wins over a same-cycle clear.
      overflow_d  = (overflow_q && !error_clear) || (write_increment && full_int && !flush);
      underflow_d = (underflow_q && !error_clear) || (read_increment && empty_int && !flush);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         read_data_q  <= '0;
         read_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         read_data_q  <= read_data_d;
         read_valid_q <= read_valid_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_accept) mem_q[wr_ptr_q] <= write_data;
   end

   always_comb begin
      full         = full_int;
      empty        = empty_int;
      level        = level_q;
      almost_full  = (level_q >= af_thresh);
      almost_empty = (level_q <= ae_thresh);
      overflow     = overflow_q;
      underflow    = underflow_q;
      if (FWFT != 0) begin
         read_data  = empty_int ? '0 : mem_q[rd_ptr_q];
         read_valid = !empty_int;
      end else begin
         read_data  = read_data_q;
         read_valid = read_valid_q;
      end
   end

endmodule

// File: doc/sync_fifo_pf.md
SYNC_FIFO_PF -- requirements
Module: sync_fifo_pf

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of each stored word.
REQ-002 Parameter ADDRESS_WIDTH, default 4; depth DEPTH = 2**ADDRESS_WIDTH entries.
REQ-003 Parameter FWFT, default 0; 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-004 Port clk, input, 1, sole clock; all state changes on rising edge.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port flush, input, 1, synchronous clear of FIFO contents.
REQ-007 Port write_increment, input, 1, write request.
REQ-008 Port write_data, input, DATA_WIDTH, word to store.
REQ-009 Port read_increment, input, 1, read/pop request.
REQ-010 Port read_data, output, DATA_WIDTH, read word.
REQ-011 Port read_valid, output, 1, read_data holds a valid popped word (FWFT=0) or a valid head word (FWFT=1).
REQ-012 Port full, output, 1, level == DEPTH.
REQ-013 Port empty, output, 1, level == 0.
REQ-014 Port level, output, ADDRESS_WIDTH+1, stored-entry count.
REQ-015 Port af_thresh / ae_thresh, input, ADDRESS_WIDTH+1 each, almost-full / almost-empty thresholds.
REQ-016 Port almost_full / almost_empty, output, 1 each, threshold flags.
REQ-017 Port overflow / underflow, output, 1 each, sticky error flags.
REQ-018 Port error_clear, input, 1, synchronous clear of overflow and underflow.

Function
REQ-019 Write accepted iff write_increment && !full && !flush; word stored at write pointer; pointer advances modulo DEPTH.
REQ-020 Read accepted iff read_increment && !empty && !flush; read pointer advances modulo DEPTH.
REQ-021 level: +1 on write-only, -1 on read-only, unchanged on both or neither; registered, never exceeds DEPTH or goes below 0.
REQ-022 Simultaneous request at full: read accepted, write rejected, overflow set; level becomes DEPTH-1.
REQ-023 Simultaneous request at empty: write accepted, read rejected, underflow set; level becomes 1.
REQ-024 Simultaneous request at 0 < level < DEPTH: both accepted, level unchanged, data order preserved.
REQ-025 full, empty, almost_full (level >= af_thresh), almost_empty (level <= ae_thresh) decoded combinationally from registered level only.
REQ-026 FWFT=0: on accepted read, read_data loads head word and read_valid is 1 the following cycle only; otherwise read_valid 0 and read_data holds last value.
REQ-027 FWFT=1: read_data = head word and read_valid = !empty continuously; accepted read exposes next word the following cycle; read_data = 0 when empty.
REQ-028 Word written into empty FIFO visible at read_data (FWFT=1) / readable (FWFT=0) the cycle after the write, not the same cycle.
REQ-029 overflow set on write_increment while full (not during flush); underflow set on read_increment while empty (not during flush); both hold until error_clear or reset.
REQ-030 error_clear and a new error event in the same cycle: flag remains set.
REQ-031 flush: pointers and level to 0, read_valid to 0 next cycle; overrides same-cycle read/write; does not alter overflow, underflow, or storage contents.
REQ-032 Pointer wrap: after DEPTH writes and DEPTH reads, order and data preserved across the wrap.

Reset
REQ-033 rst_n low asynchronously forces pointers and level to 0, empty=1, full=0, almost_empty=1 (ae_thresh >= 0), almost_full = (af_thresh == 0), read_data=0, read_valid=0, overflow=0, underflow=0.
REQ-034 Storage array not reset; contents undefined until written.
REQ-035 Reset asserted mid-operation discards all stored words; first write after release is the first word read.

Verification (DATA_WIDTH=8, ADDRESS_WIDTH=2, DEPTH=4, af_thresh=3, ae_thresh=1)
REQ-036 FWFT=0: write 0x11,0x22,0x33,0x44 -> full=1, level=4, almost_full=1; four reads -> read_data 0x11,0x22,0x33,0x44 each with read_valid one cycle after its read, then empty=1.
REQ-037 At full, assert write_increment (0x55) and read_increment together -> read yields 0x11, 0x55 dropped, overflow=1, level=3; error_clear -> overflow=0.
REQ-038 At empty, write 0xA5 and read together -> level=1, underflow=1, read_valid=0; FWFT=1 build: read_data=0xA5, read_valid=1 next cycle.
REQ-039 Six write/read pairs of 0x01..0x06 interleaved at level 2 -> output order 0x01..0x06 across pointer wrap, no flag errors.
REQ-040 level=3, assert flush with write_increment -> next cycle level=0, empty=1, write dropped, overflow unchanged.
REQ-041 level=2, drop rst_n between edges -> outputs reach REQ-033 values immediately; write 0x77 after release -> first read returns 0x77.
